// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port unified instruction/data memory between three
//   requesters: instruction fetch (IF), the load/store path (LS) and the
//   debug/program loader (DBG). One access is in flight at a time. Fixed
//   priority LS > IF > DBG, except that DBG is force-granted once it has
//   lost MAX_WAIT grants in a row while requesting.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     if_req/if_addr           fetch read request
//     ls_req/ls_we/ls_addr/ls_wdata      load/store request
//     dbg_req/dbg_we/dbg_addr/dbg_wdata  debug request
//     ack[2:0]                 one-cycle done pulse, one-hot {DBG,LS,IF}
//     rdata                    read data, valid while ack is high
//     gnt[2:0]                 current owner, one-hot {DBG,LS,IF}
//     busy                     transaction in progress
//     mem_addr/mem_wdata/mem_re/mem_we/mem_rdata   memory port
//
//   Latency from the IDLE cycle that samples a request (cycle 0):
//   write ack in cycle 2, read ack in cycle 2+RD_LAT.
module mem_port_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [2:0]    ack,
    output logic [DW-1:0] rdata,
    output logic [2:0]    gnt,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(RD_LAT + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LAT);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] dbg_wait_q, dbg_wait_d;
    logic          we_q, we_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    ack_q, ack_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;

    // Winner of the IDLE-cycle arbitration; only meaningful in IDLE.
    logic [2:0] win;

    always_comb begin
        win = 3'b000;
        if (dbg_req && (dbg_wait_q == WAIT_MAX)) begin
            win = 3'b100;       // starved debug port jumps the queue
        end else if (ls_req) begin
            win = 3'b010;
        end else if (if_req) begin
            win = 3'b001;
        end else if (dbg_req) begin
            win = 3'b100;
        end
    end

    // Outputs are registered, so the memory strobes for the ISSUE cycle are
    // computed on the IDLE->ISSUE transition and the ack for DONE is
    // computed on the transition into DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dbg_wait_d  = dbg_wait_q;
        we_d        = we_q;
        gnt_d       = gnt_q;
        ack_d       = 3'b000;
        busy_d      = busy_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Starvation counter: cleared when debug is idle or served,
                // bumped (saturating) each time debug loses a grant.
                if (!dbg_req || win[2]) begin
                    dbg_wait_d = '0;
                end else if (dbg_wait_q != WAIT_MAX) begin
                    dbg_wait_d = dbg_wait_q + WW'(1);
                end

                if (win != 3'b000) begin
                    gnt_d   = win;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                    unique case (1'b1)
                        win[1]: begin
                            we_d        = ls_we;
                            mem_addr_d  = ls_addr;
                            mem_wdata_d = ls_we ? ls_wdata : mem_wdata_q;
                        end
                        win[2]: begin
                            we_d        = dbg_we;
                            mem_addr_d  = dbg_addr;
                            mem_wdata_d = dbg_we ? dbg_wdata : mem_wdata_q;
                        end
                        default: begin
                            we_d       = 1'b0;
                            mem_addr_d = if_addr;
                        end
                    endcase
                    mem_we_d = we_d;
                    mem_re_d = !we_d;
                end
            end

            ISSUE: begin
                if (we_q) begin
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                // Counter at 1 marks the RD_LAT-th cycle after the strobe.
                if (cnt_q == CW'(1)) begin
                    rdata_d = mem_rdata;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end
            end

            DONE: begin
                gnt_d   = 3'b000;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dbg_wait_q  <= '0;
            we_q        <= 1'b0;
            gnt_q       <= 3'b000;
            ack_q       <= 3'b000;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dbg_wait_q  <= dbg_wait_d;
            we_q        <= we_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a random
// phase, checked against a transaction-level model (priority pick, starvation
// count, shadow memory, expected latency).
module tb_mem_port_arbiter;
    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, ls_req, ls_we, dbg_req, dbg_we;
    logic [AW-1:0] if_addr, ls_addr, dbg_addr;
    logic [DW-1:0] ls_wdata, dbg_wdata;
    logic [2:0]    ack, gnt;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          busy, mem_re, mem_we;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .ack(ack), .rdata(rdata), .gnt(gnt), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Initial memory contents.
    function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
        if (a == AW'(5)) return 32'hDEADBEEF;
        return 32'h1000_0000 + DW'(a) * 32'd7;
    endfunction

    // Memory environment: writes on mem_we, read data valid RD_LAT cycles
    // after the mem_re cycle, garbage otherwise.
    bit   [DW-1:0] env_mem [DEPTH];
    bit            env_wr  [DEPTH];
    logic [AW-1:0] rd_addr_pipe [RD_LAT];
    logic          rd_vld_pipe  [RD_LAT];

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            env_mem[mem_addr] <= mem_wdata;
            env_wr[mem_addr]  <= 1'b1;
        end
        rd_vld_pipe[0]  <= mem_re;
        rd_addr_pipe[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
            rd_addr_pipe[i] <= rd_addr_pipe[i-1];
        end
    end

    assign mem_rdata = (rd_vld_pipe[RD_LAT-1] === 1'b1)
                     ? (env_wr[rd_addr_pipe[RD_LAT-1]] ? env_mem[rd_addr_pipe[RD_LAT-1]]
                                                       : seed_val(rd_addr_pipe[RD_LAT-1]))
                     : 32'hBAD0BAD0;

    // Reference model state.
    logic [DW-1:0] ref_mem [DEPTH];
    int            mwait;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // 0=IF, 1=LS, 2=DBG, -1=none
    function automatic int model_pick(input bit i, input bit l, input bit d);
        if (d && mwait == MAX_WAIT) return 2;
        if (l) return 1;
        if (i) return 0;
        if (d) return 2;
        return -1;
    endfunction

    task automatic model_update(input int w, input bit d);
        if (!d || w == 2) mwait = 0;
        else if (mwait < MAX_WAIT) mwait = mwait + 1;
    endtask

    // Change a requester's fields after its grant: the DUT must have latched them.
    task automatic scramble(input int w);
        case (w)
            0: if_addr = AW'($urandom_range(0, 15));
            1: begin ls_addr = AW'($urandom_range(0, 15)); ls_wdata = $urandom; ls_we = 1'($urandom); end
            default: begin dbg_addr = AW'($urandom_range(0, 15)); dbg_wdata = $urandom; dbg_we = 1'($urandom); end
        endcase
    endtask

    // Called in an IDLE cycle with at least one request driven. Ends in the
    // following IDLE cycle. keep=1 leaves the winner's request and fields alone.
    task automatic txn(input string tag, input bit keep, output logic [2:0] got_gnt, output int ack_cyc);
        int            w, lat, exp_lat;
        logic [2:0]    eg;
        logic          twe;
        logic [AW-1:0] ta;
        logic [DW-1:0] twd;
        w = model_pick(if_req, ls_req, dbg_req);
        case (w)
            0:       begin twe = 1'b0;   ta = if_addr;  twd = '0; end
            1:       begin twe = ls_we;  ta = ls_addr;  twd = ls_wdata; end
            default: begin twe = dbg_we; ta = dbg_addr; twd = dbg_wdata; end
        endcase
        model_update(w, dbg_req);
        eg = 3'(1 << w);
        tick();
        got_gnt = gnt;
        chk({tag, ":gnt"}, 64'(gnt), 64'(eg));
        chk({tag, ":busy"}, 64'(busy), 64'd1);
        chk({tag, ":addr"}, 64'(mem_addr), 64'(ta));
        chk({tag, ":strobe"}, 64'({mem_re, mem_we}), 64'({!twe, twe}));
        if (twe) chk({tag, ":wdata"}, 64'(mem_wdata), 64'(twd));
        if (!keep) scramble(w);
        lat = 1;
        while (ack == 3'b000 && lat < 30) begin
            tick();
            lat++;
            chk({tag, ":re_we_excl"}, 64'(mem_re & mem_we), 64'd0);
        end
        ack_cyc = cyc;
        exp_lat = twe ? 2 : 2 + RD_LAT;
        chk({tag, ":ack"}, 64'(ack), 64'(eg));
        chk({tag, ":latency"}, 64'(lat), 64'(exp_lat));
        if (!twe) chk({tag, ":rdata"}, 64'(rdata), 64'(ref_mem[ta]));
        else ref_mem[ta] = twd;
        if (!keep) begin
            case (w)
                0: if_req = 1'b0;
                1: ls_req = 1'b0;
                default: dbg_req = 1'b0;
            endcase
        end
        tick();
        chk({tag, ":idle_ack"}, 64'(ack), 64'd0);
        chk({tag, ":idle_busy"}, 64'(busy), 64'd0);
        chk({tag, ":idle_gnt"}, 64'(gnt), 64'd0);
    endtask

    initial begin
        logic [2:0] g;
        int         ac, prev_ac;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(AW'(i));
        mwait = 0;
        rst = 1'b1;
        if_req = 0; ls_req = 0; dbg_req = 0; ls_we = 0; dbg_we = 0;
        if_addr = '0; ls_addr = '0; dbg_addr = '0; ls_wdata = '0; dbg_wdata = '0;
        tick(); tick();
        chk("rst:gnt", 64'(gnt), 64'd0);
        chk("rst:ack", 64'(ack), 64'd0);
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:strobes", 64'({mem_re, mem_we}), 64'd0);
        chk("rst:addr", 64'(mem_addr), 64'd0);
        chk("rst:rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        tick();

        // LS load of addr 5: ack with DEADBEEF in cycle 2+RD_LAT.
        ls_req = 1; ls_we = 0; ls_addr = AW'(5);
        txn("ls_load", 1'b0, g, ac);
        chk("ls_load:value", 64'(rdata), 64'h0000_0000_DEAD_BEEF);

        // IF + LS store together: LS first, IF next.
        if_req = 1; if_addr = AW'(3);
        ls_req = 1; ls_we = 1; ls_addr = AW'(3); ls_wdata = 32'h12;
        txn("pri_ls", 1'b0, g, ac);
        chk("pri_ls:owner", 64'(g), 64'(3'b010));
        txn("pri_if", 1'b0, g, ac);
        chk("pri_if:owner", 64'(g), 64'(3'b001));
        chk("pri_if:value", 64'(rdata), 64'h12);

        // Starvation: LS held with toggling addr, DBG held.
        ls_req = 1; ls_we = 0; dbg_req = 1; dbg_we = 0; dbg_addr = AW'(5);
        for (int k = 0; k < 10; k++) begin
            ls_addr = AW'(k);
            txn("starve", 1'b1, g, ac);
            chk("starve:owner", 64'(g), (k == 4 || k == 9) ? 64'(3'b100) : 64'(3'b010));
        end
        ls_req = 0; dbg_req = 0;
        tick();
        model_update(-1, 1'b0);

        // DBG write then read back.
        dbg_req = 1; dbg_we = 1; dbg_addr = AW'(7); dbg_wdata = 32'hA5;
        txn("dbg_wr", 1'b0, g, ac);
        dbg_req = 1; dbg_we = 0; dbg_addr = AW'(7);
        txn("dbg_rd", 1'b0, g, ac);
        chk("dbg_rd:value", 64'(rdata), 64'hA5);

        // Reset during WAIT drops the access.
        if_req = 1; if_addr = AW'(9);
        tick();
        if_req = 0;
        chk("rstw:issue_re", 64'(mem_re), 64'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rstw:busy", 64'(busy), 64'd0);
        chk("rstw:gnt", 64'(gnt), 64'd0);
        chk("rstw:re", 64'(mem_re), 64'd0);
        chk("rstw:ack", 64'(ack), 64'd0);
        tick();
        chk("rstw:ack_hold", 64'(ack), 64'd0);
        rst = 1'b0;
        mwait = 0;
        for (int k = 0; k < RD_LAT + 2; k++) begin
            tick();
            chk("rstw:no_ack", 64'(ack), 64'd0);
        end
        if_req = 1; if_addr = AW'(9);
        txn("rstw:fresh", 1'b0, g, ac);

        // IF held for three back-to-back fetches.
        if_req = 1; if_addr = AW'(20);
        txn("b2b0", 1'b1, g, prev_ac);
        for (int k = 1; k < 3; k++) begin
            if_addr = AW'(20 + k);
            txn("b2b", k == 2 ? 1'b0 : 1'b1, g, ac);
            chk("b2b:spacing", 64'(ac - prev_ac), 64'(RD_LAT + 3));
            prev_ac = ac;
        end

        // Random mix.
        for (int n = 0; n < 60; n++) begin
            if_req = 1'($urandom); ls_req = 1'($urandom); dbg_req = 1'($urandom);
            ls_we = 1'($urandom); dbg_we = 1'($urandom);
            if_addr = AW'($urandom_range(0, 15));
            ls_addr = AW'($urandom_range(0, 15));
            dbg_addr = AW'($urandom_range(0, 15));
            ls_wdata = $urandom; dbg_wdata = $urandom;
            if (if_req || ls_req || dbg_req) begin
                txn("rand", 1'b0, g, ac);
            end else begin
                model_update(-1, 1'b0);
                tick();
                chk("rand:idle_busy", 64'(busy), 64'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
